// File: rtl/axi_lite_mem_model.sv
// axi_lite_mem_model: parametrised AXI4-lite slave memory with latency, optional ready stalls, SLVERR and counters
// Ports: peripheral_clock, peripheral_reset (asynchronous, active-high);
//   axi_aw*/axi_w*/axi_b*/axi_ar*/axi_r* : AXI4-lite slave channels (prot ignored);
//   wr_cnt/rd_cnt : completed B/R handshakes (wrapping); err_cnt : SLVERR handshakes (saturating).
module axi_lite_mem_model #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int WR_LATENCY = 2,
  parameter int RD_LATENCY = 3,
  parameter int STALL_MODE = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic peripheral_clock,
  input  logic peripheral_reset,
  input  logic [ADDR_W-1:0] axi_awaddr,
  input  logic [2:0] axi_awprot,
  input  logic axi_awvalid,
  output logic axi_awready,
  input  logic [DATA_W-1:0] axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic axi_wvalid,
  output logic axi_wready,
  output logic [1:0] axi_bresp,
  output logic axi_bvalid,
  input  logic axi_bready,
  input  logic [ADDR_W-1:0] axi_araddr,
  input  logic [2:0] axi_arprot,
  input  logic axi_arvalid,
  output logic axi_arready,
  output logic [DATA_W-1:0] axi_rdata,
  output logic [1:0] axi_rresp,
  output logic axi_rvalid,
  input  logic axi_rready,
  output logic [31:0] wr_cnt,
  output logic [31:0] rd_cnt,
  output logic [15:0] err_cnt
);
  localparam int SW = DATA_W / 8;
  localparam int LG = $clog2(SW);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = 16;
  typedef enum logic [1:0] {WR_COLLECT, WR_WAIT, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic live, stall, unused_prot;
  logic [15:0] lfsr;
  logic aw_got, w_got, aw_hs, w_hs, b_hs, ar_hs, r_hs, both, commit, sample, wr_ok, rd_ok;
  logic [CW-1:0] wr_lat, rd_lat;
  logic [ADDR_W-1:0] aw_addr_q, ar_addr_q, wr_off, rd_off;
  logic [DATA_W-1:0] w_data_q, wr_merged, rd_word;
  logic [SW-1:0] w_strb_q;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [1:0] err_inc;
  logic [16:0] err_sum;
  assign unused_prot = ^{axi_awprot, axi_arprot};
  // live keeps every ready low while reset is held and for the edge that releases it
  assign stall = STALL_MODE != 0 && lfsr[1:0] == 2'b11;
  assign axi_awready = live && !stall && wr_state == WR_COLLECT && !aw_got;
  assign axi_wready = live && !stall && wr_state == WR_COLLECT && !w_got;
  assign axi_arready = live && !stall && rd_state == RD_IDLE;
  assign axi_bvalid = wr_state == WR_RESP;
  assign axi_rvalid = rd_state == RD_RESP;
  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs = axi_wvalid && axi_wready;
  assign b_hs = axi_bvalid && axi_bready;
  assign ar_hs = axi_arvalid && axi_arready;
  assign r_hs = axi_rvalid && axi_rready;
  assign both = (aw_got || aw_hs) && (w_got || w_hs);
  assign commit = wr_state == WR_WAIT && wr_lat == '0;
  assign sample = rd_state == RD_WAIT && rd_lat == '0;
  assign wr_off = (aw_addr_q - BASE_ADDR) >> LG;
  assign rd_off = (ar_addr_q - BASE_ADDR) >> LG;
  assign wr_ok = aw_addr_q >= BASE_ADDR && wr_off < ADDR_W'(DEPTH);
  assign rd_ok = ar_addr_q >= BASE_ADDR && rd_off < ADDR_W'(DEPTH);
  assign wr_idx = wr_off[IW-1:0];
  assign rd_idx = rd_off[IW-1:0];
  // a read sampling the word being committed this cycle sees the merged new data
  assign rd_word = commit && wr_ok && wr_idx == rd_idx ? wr_merged : mem[rd_idx];
  assign err_inc = {1'b0, b_hs && axi_bresp[1]} + {1'b0, r_hs && axi_rresp[1]};
  assign err_sum = {1'b0, err_cnt} + {15'd0, err_inc};
  always_comb begin
    wr_next = wr_state;
    rd_next = rd_state;
    wr_next = wr_state == WR_COLLECT ? (both ? WR_WAIT : WR_COLLECT) :
              wr_state == WR_WAIT ? (commit ? WR_RESP : WR_WAIT) : (b_hs ? WR_COLLECT : WR_RESP);
    rd_next = rd_state == RD_IDLE ? (ar_hs ? RD_WAIT : RD_IDLE) :
              rd_state == RD_WAIT ? (sample ? RD_RESP : RD_WAIT) : (r_hs ? RD_IDLE : RD_RESP);
  end
  always_comb begin
    wr_merged = mem[wr_idx];
    for (int b = 0; b < SW; b++) if (w_strb_q[b]) wr_merged[8*b +: 8] = w_data_q[8*b +: 8];
  end
  always_ff @(posedge peripheral_clock or posedge peripheral_reset)
    if (peripheral_reset) begin
      wr_state <= WR_COLLECT;
      rd_state <= RD_IDLE;
      live <= 1'b0;
      lfsr <= LFSR_SEED;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      wr_lat <= '0;
      rd_lat <= '0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      axi_bresp <= '0;
      axi_rresp <= '0;
      axi_rdata <= '0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      err_cnt <= '0;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
      live <= 1'b1;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      aw_got <= wr_state == WR_COLLECT && (aw_got || aw_hs) && !both;
      w_got <= wr_state == WR_COLLECT && (w_got || w_hs) && !both;
      if (aw_hs) aw_addr_q <= axi_awaddr;
      if (w_hs) w_data_q <= axi_wdata;
      if (w_hs) w_strb_q <= axi_wstrb;
      if (ar_hs) ar_addr_q <= axi_araddr;
      if (both) wr_lat <= CW'(WR_LATENCY);
      else if (wr_state == WR_WAIT && wr_lat != '0) wr_lat <= wr_lat - 1'b1;
      if (ar_hs) rd_lat <= CW'(RD_LATENCY);
      else if (rd_state == RD_WAIT && rd_lat != '0) rd_lat <= rd_lat - 1'b1;
      if (commit) axi_bresp <= wr_ok ? 2'b00 : 2'b10;
      if (sample) axi_rresp <= rd_ok ? 2'b00 : 2'b10;
      if (sample) axi_rdata <= rd_ok ? rd_word : '0;
      if (b_hs) wr_cnt <= wr_cnt + 1;
      if (r_hs) rd_cnt <= rd_cnt + 1;
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  always_ff @(posedge peripheral_clock)
    if (commit && wr_ok) mem[wr_idx] <= wr_merged;
endmodule

// File: tb/tb_axi_lite_mem_model.sv
// tb_axi_lite_mem_model: directed checks of axi_lite_mem_model; instance 0 without stalls, instance 1 with LFSR stalls
module tb_axi_lite_mem_model;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int DEPTH = 64;
  logic peripheral_clock = 1'b0;
  logic peripheral_reset = 1'b1;
  always #5 peripheral_clock = ~peripheral_clock;
  logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2], wr_cnt [2], rd_cnt [2];
  logic [3:0] wstrb [2];
  logic awvalid [2], awready [2], wvalid [2], wready [2], bvalid [2], bready [2];
  logic arvalid [2], arready [2], rvalid [2], rready [2];
  logic [1:0] bresp [2], rresp [2];
  logic [15:0] err_cnt [2];
  int n_checks = 0;
  int n_errors = 0;
  int stalls = 0;
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    axi_lite_mem_model #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
      .WR_LATENCY(2), .RD_LATENCY(3), .STALL_MODE(g), .LFSR_SEED(16'hACE1)
    ) u_dut (
      .peripheral_clock(peripheral_clock),
      .peripheral_reset(peripheral_reset),
      .axi_awaddr(awaddr[g]),
      .axi_awprot(3'b000),
      .axi_awvalid(awvalid[g]),
      .axi_awready(awready[g]),
      .axi_wdata(wdata[g]),
      .axi_wstrb(wstrb[g]),
      .axi_wvalid(wvalid[g]),
      .axi_wready(wready[g]),
      .axi_bresp(bresp[g]),
      .axi_bvalid(bvalid[g]),
      .axi_bready(bready[g]),
      .axi_araddr(araddr[g]),
      .axi_arprot(3'b000),
      .axi_arvalid(arvalid[g]),
      .axi_arready(arready[g]),
      .axi_rdata(rdata[g]),
      .axi_rresp(rresp[g]),
      .axi_rvalid(rvalid[g]),
      .axi_rready(rready[g]),
      .wr_cnt(wr_cnt[g]),
      .rd_cnt(rd_cnt[g]),
      .err_cnt(err_cnt[g])
    );
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge peripheral_clock);
    #1;
  endtask
  // lat = cycles from the later AW/W handshake to the first cycle bvalid is seen
  task automatic axi_write(input int d, input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    int t;
    logic aw_h, w_h;
    t = 0;
    awaddr[d] = a;
    wdata[d] = dat;
    wstrb[d] = s;
    awvalid[d] = 1'b1;
    wvalid[d] = 1'b1;
    bready[d] = 1'b1;
    while ((awvalid[d] || wvalid[d]) && t < 300) begin
      aw_h = awvalid[d] && awready[d];
      w_h = wvalid[d] && wready[d];
      tick();
      t++;
      if (aw_h) awvalid[d] = 1'b0;
      if (w_h) wvalid[d] = 1'b0;
    end
    lat = 0;
    while (!bvalid[d] && t < 300) begin
      tick();
      lat++;
      t++;
    end
    check("wr_done", bvalid[d], 1);
    resp = bresp[d];
    tick();
    awvalid[d] = 1'b0;
    wvalid[d] = 1'b0;
  endtask
  task automatic axi_read(input int d, input logic [31:0] a, output logic [31:0] dat,
                          output logic [1:0] resp, output int lat);
    int t;
    logic h;
    t = 0;
    araddr[d] = a;
    arvalid[d] = 1'b1;
    rready[d] = 1'b1;
    while (arvalid[d] && t < 300) begin
      h = arready[d];
      if (d == 1 && !h) stalls++;
      tick();
      t++;
      if (h) arvalid[d] = 1'b0;
    end
    lat = 0;
    while (!rvalid[d] && t < 300) begin
      tick();
      lat++;
      t++;
    end
    check("rd_done", rvalid[d], 1);
    dat = rdata[d];
    resp = rresp[d];
    tick();
    arvalid[d] = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] resp;
    logic [31:0] dat, cnt0;
    logic [31:0] addrs [200];
    logic [31:0] model [DEPTH];
    logic got, stable;
    int lat, w;
    for (int d = 0; d < 2; d++) begin
      awaddr[d] = '0;
      wdata[d] = '0;
      wstrb[d] = '0;
      araddr[d] = '0;
      awvalid[d] = 1'b0;
      wvalid[d] = 1'b0;
      arvalid[d] = 1'b0;
      bready[d] = 1'b0;
      rready[d] = 1'b0;
    end
    repeat (2) tick();
    check("rst_awready", awready[0], 0);
    check("rst_wready", wready[0], 0);
    check("rst_arready", arready[0], 0);
    check("rst_bvalid", bvalid[0], 0);
    check("rst_rvalid", rvalid[0], 0);
    check("rst_rdata", rdata[0], 0);
    check("rst_cnts", {wr_cnt[0], rd_cnt[0]}, 0);
    peripheral_reset = 1'b0;
    tick();
    check("rel_awready", awready[0], 1);
    check("rel_arready", arready[0], 1);
    axi_write(0, BASE + 8, 32'hDEADBEEF, 4'hF, resp, lat);
    check("basic_bresp", resp, 0);
    check("basic_wr_lat", lat, 3);
    check("basic_wr_cnt", wr_cnt[0], 1);
    axi_read(0, BASE + 8, dat, resp, lat);
    check("basic_rdata", dat, 32'hDEADBEEF);
    check("basic_rresp", resp, 0);
    check("basic_rd_lat", lat, 4);
    check("basic_rd_cnt", rd_cnt[0], 1);
    axi_write(0, BASE + 16, 32'hFFFFFFFF, 4'hF, resp, lat);
    wdata[0] = 32'h11223344;
    wstrb[0] = 4'b0101;
    wvalid[0] = 1'b1;
    bready[0] = 1'b1;
    check("wfirst_wready", wready[0], 1);
    tick();
    wvalid[0] = 1'b0;
    check("wfirst_wready_low", wready[0], 0);
    awaddr[0] = BASE + 16;
    awvalid[0] = 1'b1;
    check("wfirst_awready", awready[0], 1);
    tick();
    awvalid[0] = 1'b0;
    lat = 0;
    while (!bvalid[0] && lat < 20) begin
      tick();
      lat++;
    end
    check("wfirst_lat", lat, 3);
    tick();
    axi_read(0, BASE + 16, dat, resp, lat);
    check("wfirst_rdata", dat, 32'hFF22FF44);
    axi_write(0, BASE + 32, 32'hAABBCCDD, 4'hF, resp, lat);
    araddr[0] = BASE + 32;
    arvalid[0] = 1'b1;
    rready[0] = 1'b1;
    tick();
    arvalid[0] = 1'b0;
    awaddr[0] = BASE + 32;
    wdata[0] = 32'h00001122;
    wstrb[0] = 4'b0011;
    awvalid[0] = 1'b1;
    wvalid[0] = 1'b1;
    bready[0] = 1'b1;
    tick();
    awvalid[0] = 1'b0;
    wvalid[0] = 1'b0;
    got = 1'b0;
    dat = '0;
    for (int i = 0; i < 12; i++) begin
      if (rvalid[0] && !got) begin
        dat = rdata[0];
        got = 1'b1;
      end
      tick();
    end
    check("bypass_seen", got, 1);
    check("bypass_rdata", dat, 32'hAABB1122);
    axi_read(0, BASE + 32, dat, resp, lat);
    check("bypass_mem", dat, 32'hAABB1122);
    axi_read(0, BASE + DEPTH * 4, dat, resp, lat);
    check("oor_rresp", resp, 2'b10);
    check("oor_rdata", dat, 0);
    check("oor_err1", err_cnt[0], 1);
    axi_write(0, BASE + DEPTH * 4, 32'h12345678, 4'hF, resp, lat);
    check("oor_bresp", resp, 2'b10);
    check("oor_err2", err_cnt[0], 2);
    axi_read(0, BASE, dat, resp, lat);
    check("oor_alias_rdata", dat, 0);
    check("oor_alias_rresp", resp, 0);
    axi_read(0, BASE - 4, dat, resp, lat);
    check("below_rresp", resp, 2'b10);
    check("below_err3", err_cnt[0], 3);
    axi_read(0, BASE + DEPTH * 4 - 4, dat, resp, lat);
    check("last_rresp", resp, 0);
    check("cnt_wr6", wr_cnt[0], 6);
    check("cnt_rd8", rd_cnt[0], 8);
    araddr[0] = BASE + 8;
    arvalid[0] = 1'b1;
    rready[0] = 1'b0;
    tick();
    arvalid[0] = 1'b0;
    lat = 0;
    while (!rvalid[0] && lat < 20) begin
      tick();
      lat++;
    end
    cnt0 = rd_cnt[0];
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!rvalid[0] || rdata[0] !== 32'hDEADBEEF || arready[0]) stable = 1'b0;
      tick();
    end
    check("hold_stable", stable, 1);
    check("hold_rvalid", rvalid[0], 1);
    check("hold_rd_cnt", rd_cnt[0], 8);
    rready[0] = 1'b1;
    tick();
    check("hold_rvalid_drop", rvalid[0], 0);
    check("hold_rd_cnt_inc", rd_cnt[0], cnt0 + 1);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < 200; i++) begin
      w = $urandom_range(0, DEPTH - 1);
      dat = $urandom;
      addrs[i] = BASE + w * 4;
      model[w] = dat;
      axi_write(1, addrs[i], dat, 4'hF, resp, lat);
    end
    for (int i = 0; i < 200; i++) begin
      axi_read(1, addrs[i], dat, resp, lat);
      check("stall_rdata", dat, model[(addrs[i] - BASE) >> 2]);
    end
    check("stall_wr_cnt", wr_cnt[1], 200);
    check("stall_rd_cnt", rd_cnt[1], 200);
    check("stall_err_cnt", err_cnt[1], 0);
    check("stall_seen", stalls > 0, 1);
    araddr[0] = BASE + 8;
    arvalid[0] = 1'b1;
    rready[0] = 1'b0;
    tick();
    arvalid[0] = 1'b0;
    repeat (4) tick();
    check("pre_rst_rvalid", rvalid[0], 1);
    awaddr[0] = BASE + 48;
    wdata[0] = 32'h55555555;
    wstrb[0] = 4'hF;
    awvalid[0] = 1'b1;
    wvalid[0] = 1'b1;
    bready[0] = 1'b1;
    tick();
    awvalid[0] = 1'b0;
    wvalid[0] = 1'b0;
    tick();
    peripheral_reset = 1'b1;
    #1;
    check("async_rvalid", rvalid[0], 0);
    check("async_bvalid", bvalid[0], 0);
    check("async_awready", awready[0], 0);
    check("async_cnts", {wr_cnt[0], rd_cnt[0], 16'(err_cnt[0])}, 0);
    tick();
    tick();
    peripheral_reset = 1'b0;
    rready[0] = 1'b1;
    tick();
    check("rst_rel_awready", awready[0], 1);
    axi_read(0, BASE + 48, dat, resp, lat);
    check("rst_dropped_write", dat, 0);
    axi_read(0, BASE + 8, dat, resp, lat);
    check("rst_kept_write", dat, 32'hDEADBEEF);
    check("rst_rd_cnt", rd_cnt[0], 2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
